// File: rtl/ssc_pkg.sv
// Shared constants for the correlation-seen collector: register map,
// event-queue entry layout and the address decode helper.
package ssc_pkg;

   localparam logic [15:0] CSEEN_ADDR = 16'h0108;
   localparam logic [15:0] EVQ_ADDR   = 16'h010C;
   localparam logic [15:0] IMASK_ADDR = 16'h0110;
   localparam logic [15:0] EVST_ADDR  = 16'h0114;

   // Pop-word layout: {valid, ovf, 18'b0, count[5:0], 1'b0, idx[4:0]}
   localparam int EVQ_IDX_LSB   = 0;
   localparam int EVQ_IDX_W     = 5;
   localparam int EVQ_CNT_LSB   = 6;
   localparam int EVQ_CNT_W     = 6;
   localparam int EVQ_OVF_BIT   = 30;
   localparam int EVQ_VALID_BIT = 31;

   localparam int EVST_OVF_BIT   = 31;
   localparam int EVST_FLUSH_BIT = 0;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_CSEEN,
      REG_EVQ,
      REG_IMASK,
      REG_EVST
   } regSelT;

   function automatic regSelT decodeReg(input logic [15:0] addr);
      case (addr)
         CSEEN_ADDR: return REG_CSEEN;
         EVQ_ADDR:   return REG_EVQ;
         IMASK_ADDR: return REG_IMASK;
         EVST_ADDR:  return REG_EVST;
         default:    return REG_NONE;
      endcase
   endfunction

   function automatic logic [31:0] packEvq(input logic valid, input logic ovf,
                                           input logic [EVQ_CNT_W-1:0] cnt,
                                           input logic [EVQ_IDX_W-1:0] idx);
      logic [31:0] word;
      word = '0;
      word[EVQ_VALID_BIT]             = valid;
      word[EVQ_OVF_BIT]               = ovf;
      word[EVQ_CNT_LSB +: EVQ_CNT_W]  = cnt;
      word[EVQ_IDX_LSB +: EVQ_IDX_W]  = idx;
      return word;
   endfunction

endpackage

// File: rtl/corr_seen_collector_if.sv
// Register bus shared by the correlator channels and the collector.
interface corr_seen_collector_if;

   logic [31:0] addr;
   logic [31:0] Wdata;
   logic        write;
   logic        read;
   logic [31:0] Rdata;

   modport master (output addr, output Wdata, output write, output read, input Rdata);
   modport slave  (input addr, input Wdata, input write, input read, output Rdata);

endinterface

// File: rtl/ssc_event_fifo.sv
// Synchronous FIFO holding channel indices of detection events.
// A push into a full FIFO is accepted only when a pop frees space in the same cycle.
module ssc_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign doPop   = pop_i && !empty_o && !flush_i;
   assign doPush  = push_i && !flush_i && (!full_o || doPop);
   assign rdata_o = mem_q[rdPtr_q];
   assign count_o = count_q;

   // Pointers rely on natural binary wrap since DEPTH is a power of two
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PW'(1);
         if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
         count_d = count_q + CW'(doPush) - CW'(doPop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/corr_seen_collector.sv
// Collects per-channel correlation-detect flags into a sticky clear-on-read
// register, an ordered event queue and a maskable interrupt.
module corr_seen_collector
   import ssc_pkg::*;
#(
   parameter int NCH        = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   corr_seen_collector_if.slave  bus,
   input  logic [NCH-1:0]        cseen,
   output logic                  irq
);

   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [NCH-1:0] cseenDly_q;
   logic [NCH-1:0] seen_q, seen_d;
   logic [NCH-1:0] mask_q, mask_d;
   logic [NCH-1:0] pending_q, pending_d;
   logic           ovf_q, ovf_d;
   logic           irq_q;

   logic [NCH-1:0] risingEdge;
   logic [NCH-1:0] pendOneHot;
   logic [4:0]     pendIdx;
   logic           anyPending;
   regSelT         regSel;
   logic           wrEn, rdEn;
   logic           seenRd, popReq, flushReq, ovfClr, pushReq, popOk, drop;
   logic [4:0]     fifoHead;
   logic [CW-1:0]  fifoCount;
   logic [5:0]     count6;
   logic           fifoFull, fifoEmpty;
   logic           unusedBits;

   assign risingEdge = cseen & ~cseenDly_q;
   assign regSel     = decodeReg(bus.addr[15:0]);
   assign wrEn       = bus.write;
   assign rdEn       = bus.read && !bus.write;
   assign seenRd     = rdEn && (regSel == REG_CSEEN);
   assign popReq     = rdEn && (regSel == REG_EVQ);
   assign flushReq   = wrEn && (regSel == REG_EVST) && bus.Wdata[EVST_FLUSH_BIT];
   assign ovfClr     = wrEn && (regSel == REG_EVST) && bus.Wdata[EVST_OVF_BIT];
   assign anyPending = |pending_q;
   assign pushReq    = anyPending && !flushReq;
   assign popOk      = popReq && !fifoEmpty;
   assign drop       = pushReq && fifoFull && !popOk;
   assign count6     = 6'(fifoCount);
   assign irq        = irq_q;
   assign unusedBits = ^{bus.addr[31:16], bus.Wdata};

   // Lowest-index pending channel wins; scanning downward leaves the lowest set bit last
   always_comb begin
      pendIdx    = '0;
      pendOneHot = '0;
      for (int i = NCH-1; i >= 0; i--) begin
         if (pending_q[i]) begin
            pendIdx       = 5'(i);
            pendOneHot    = '0;
            pendOneHot[i] = 1'b1;
         end
      end
   end

   ssc_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (5)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (pushReq),
      .pop_i   (popReq),
      .flush_i (flushReq),
      .wdata_i (pendIdx),
      .rdata_o (fifoHead),
      .count_o (fifoCount),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   // A read of seen clears every bit it returned; edges landing the same cycle are ORed back in
   always_comb begin
      seen_d    = (seenRd ? '0 : seen_q) | risingEdge;
      mask_d    = mask_q;
      pending_d = pending_q;
      ovf_d     = ovf_q;
      if (wrEn && (regSel == REG_IMASK)) mask_d = bus.Wdata[NCH-1:0];
      if (flushReq)     pending_d = '0;
      else if (pushReq) pending_d = pending_q & ~pendOneHot;
      pending_d = pending_d | risingEdge;
      if (ovfClr) ovf_d = 1'b0;
      if (drop)   ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cseenDly_q <= '0;
         seen_q     <= '0;
         mask_q     <= '0;
         pending_q  <= '0;
         ovf_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         cseenDly_q <= cseen;
         seen_q     <= seen_d;
         mask_q     <= mask_d;
         pending_q  <= pending_d;
         ovf_q      <= ovf_d;
         irq_q      <= |(seen_q & mask_q);
      end
   end

   // Head index is forced to zero when empty so stale storage never leaks out
   always_comb begin
      bus.Rdata = '0;
      if (bus.read) begin
         case (regSel)
            REG_CSEEN: bus.Rdata = 32'(seen_q);
            REG_EVQ:   bus.Rdata = packEvq(!fifoEmpty, ovf_q, count6,
                                           fifoEmpty ? 5'd0 : fifoHead);
            REG_IMASK: bus.Rdata = 32'(mask_q);
            REG_EVST:  bus.Rdata = {ovf_q, 25'b0, count6};
            default:   bus.Rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_corr_seen_collector.sv
// Scoreboard bench for corr_seen_collector: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_corr_seen_collector;

   localparam int NCH   = 32;
   localparam int DEPTH = 8;

   typedef struct {
      logic [31:0] rdata;
      logic        irq;
      string       name;
   } expT;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] csDrive = '0;
   logic           irq;
   int             checkCount = 0;
   int             missCount = 0;
   expT            sbQ[$];

   // Reference model state
   logic [NCH-1:0] mSeen, mMask, mPend, mPrev;
   int             mQ[$];
   logic           mOvf, mIrq;

   corr_seen_collector_if busIf();

   corr_seen_collector #(
      .NCH        (NCH),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busIf),
      .cseen (csDrive),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void modelReset();
      mSeen = '0;
      mMask = '0;
      mPend = '0;
      mPrev = '0;
      mOvf  = 1'b0;
      mIrq  = 1'b0;
      mQ.delete();
   endfunction

   function automatic logic [31:0] modelRead(input logic [15:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         16'h0108: r = mSeen;
         16'h010C: begin
            if (mQ.size() > 0) begin
               r[31]  = 1'b1;
               r[4:0] = 5'(mQ[0]);
            end
            r[30]   = mOvf;
            r[11:6] = 6'(mQ.size());
         end
         16'h0110: r = mMask;
         16'h0114: begin
            r[31]  = mOvf;
            r[5:0] = 6'(mQ.size());
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic void modelStep(input logic rdIn, input logic wr, input logic [15:0] a,
                                     input logic [31:0] wd, input logic [NCH-1:0] cs);
      logic [NCH-1:0] edgeV;
      logic           rd, flush, irqNext;
      int             lo;
      edgeV   = cs & ~mPrev;
      mPrev   = cs;
      rd      = rdIn && !wr;
      irqNext = |(mSeen & mMask);
      if (rd && a == 16'h0108) mSeen = edgeV;
      else                     mSeen = mSeen | edgeV;
      flush = wr && a == 16'h0114 && wd[0];
      if (wr && a == 16'h0114 && wd[31]) mOvf = 1'b0;
      if (wr && a == 16'h0110) mMask = wd;
      if (rd && a == 16'h010C && mQ.size() > 0) void'(mQ.pop_front());
      if (flush) begin
         mQ.delete();
         mPend = '0;
      end else if (mPend != '0) begin
         lo = 0;
         for (int i = NCH-1; i >= 0; i--) if (mPend[i]) lo = i;
         mPend[lo] = 1'b0;
         if (mQ.size() < DEPTH) mQ.push_back(lo);
         else                   mOvf = 1'b1;
      end
      mPend = mPend | edgeV;
      mIrq  = irqNext;
   endfunction

   task automatic checkOutput(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
      end
   endtask

   // Called just after a rising edge; drives one bus cycle and advances the model
   task automatic applyStimulus(input string name, input bit rd, input bit wr,
                                input logic [31:0] a, input logic [31:0] wd);
      expT e;
      busIf.read  = rd;
      busIf.write = wr;
      busIf.addr  = a;
      busIf.Wdata = wd;
      if (rd) begin
         e.rdata = modelRead(a[15:0]);
         e.irq   = mIrq;
         e.name  = name;
         sbQ.push_back(e);
      end
      @(posedge clk);
      if (!rst_n) modelReset();
      else        modelStep(rd, wr, a[15:0], wd, csDrive);
      #1;
      busIf.read  = 1'b0;
      busIf.write = 1'b0;
   endtask

   task automatic rdReg(input string name, input logic [31:0] a);
      applyStimulus(name, 1'b1, 1'b0, a, 32'h0);
   endtask

   task automatic wrReg(input logic [31:0] a, input logic [31:0] d);
      applyStimulus("write", 1'b0, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) rdReg("idle", 32'h0000_0000);
   endtask

   // Monitor: every read cycle pops one expectation and compares data and irq
   always @(negedge clk) begin
      expT e;
      if (busIf.read) begin
         if (sbQ.size() == 0) begin
            checkCount++;
            missCount++;
            $display("[TB] FAIL unexpectedRead: got read with empty scoreboard, required an expectation");
         end else begin
            e = sbQ.pop_front();
            checkOutput(e.name, "rdata", busIf.Rdata, e.rdata);
            checkOutput(e.name, "irq", {31'b0, irq}, {31'b0, e.irq});
         end
      end
   end

   initial begin
      logic [31:0] addrList [8];
      int          r;
      addrList = '{32'h0108, 32'h010C, 32'h0110, 32'h0114,
                   32'h0000, 32'h0118, 32'hABCD_0108, 32'h0001_010C};
      busIf.read  = 1'b0;
      busIf.write = 1'b0;
      busIf.addr  = '0;
      busIf.Wdata = '0;
      modelReset();
      @(posedge clk);
      #1;

      // Reset state: every register reads zero while reset is held
      rdReg("rstSeen", 32'h0108);
      rdReg("rstEvq", 32'h010C);
      rdReg("rstMask", 32'h0110);
      rdReg("rstStatus", 32'h0114);
      rst_n = 1'b1;
      idle(1);

      // Single channel pulse held for four cycles
      wrReg(32'h0110, 32'h8);
      csDrive = 32'h8;
      idle(4);
      csDrive = '0;
      rdReg("t1Status", 32'h0114);
      rdReg("t1Seen", 32'h0108);
      idle(3);
      rdReg("t1Pop", 32'h010C);
      rdReg("t1PopEmpty", 32'h010C);

      // Simultaneous edges drain in ascending order
      csDrive = (32'h1 << 28) | (32'h1 << 5) | 32'h1;
      idle(1);
      csDrive = '0;
      idle(4);
      for (int i = 0; i < 4; i++) rdReg("t2Pop", 32'h010C);

      // Overflow with ten single edges and no pops
      for (int i = 0; i < 10; i++) begin
         csDrive = 32'h1 << (8 + i);
         idle(1);
      end
      csDrive = '0;
      idle(3);
      rdReg("t3StatusOvf", 32'h0114);
      wrReg(32'h0114, 32'h8000_0000);
      rdReg("t3StatusClr", 32'h0114);

      // Full queue: pop in the push cycle makes room
      csDrive = 32'h80;
      idle(1);
      rdReg("t4PopPush", 32'h010C);
      csDrive = '0;
      rdReg("t4Status", 32'h0114);
      wrReg(32'h0114, 32'h0000_0001);
      rdReg("t4Flush", 32'h0114);

      // Edge arriving during a seen read survives the clear
      rdReg("t5Clear", 32'h0108);
      csDrive = 32'h4;
      idle(1);
      csDrive = '0;
      idle(1);
      csDrive = 32'h4;
      rdReg("t5SeenRd", 32'h0108);
      csDrive = '0;
      rdReg("t5SeenAfter", 32'h0108);
      wrReg(32'h0114, 32'h0000_0001);

      // Reset mid-operation with queued events and irq asserted
      wrReg(32'h0110, 32'hFFFF_FFFF);
      csDrive = 32'h0000_0070;
      idle(1);
      csDrive = '0;
      idle(5);
      rdReg("t6PreRst", 32'h0114);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("t6RstNow", "irq", {31'b0, irq}, 32'h0);
      csDrive = 32'h2;
      rdReg("t6RstStatus", 32'h0114);
      rdReg("t6RstSeen", 32'h0108);
      rdReg("t6RstMask", 32'h0110);
      rst_n = 1'b1;
      idle(3);
      rdReg("t6Status", 32'h0114);
      rdReg("t6Pop", 32'h010C);
      idle(3);
      rdReg("t6PopEmpty", 32'h010C);
      csDrive = '0;

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         csDrive = csDrive ^ ($urandom & $urandom & $urandom & $urandom);
         r = $urandom_range(0, 99);
         if (r < 40)      rdReg("rand", addrList[$urandom_range(0, 7)]);
         else if (r < 45) wrReg(32'h0110, $urandom);
         else if (r < 48) wrReg(32'h0114, {1'($urandom_range(0, 1)), 30'b0,
                                            1'($urandom_range(0, 9) == 0)});
         else             applyStimulus("none", 1'b0, 1'b0, 32'h0, 32'h0);
      end

      idle(2);
      checkOutput("sbDrain", "leftover", 32'(sbQ.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
      $finish;
   end

endmodule
